truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all 16 abcd vectors, captures F and compares it against a golden truth table
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_count,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  idx;
  logic [3:0]  settle_cnt;
  logic [15:0] exp_q;

  assign abcd = idx;
  assign busy = (state != IDLE);

  // State register; reset wins over everything, including a same-cycle start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: settle for SETTLE_CYCLES, sample once, repeat for 16 vectors, then one finish cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 4'd15) ? FINISH : SETTLE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the golden table at start, record F per vector, count mismatches, report at finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx            <= 4'd0;
      settle_cnt     <= 4'd0;
      exp_q          <= 16'd0;
      table_out      <= 16'd0;
      mismatch_count <= 5'd0;
      pass           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q          <= expected;
            table_out      <= 16'd0;
            mismatch_count <= 5'd0;
            pass           <= 1'b0;
            idx            <= 4'd0;
            settle_cnt     <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          table_out[idx] <= f_in;
          // At most 16 increments per sweep, so the 5-bit count cannot wrap.
          if (f_in != exp_q[idx]) begin
            mismatch_count <= mismatch_count + 5'd1;
          end
          if (idx == 4'd15) begin
            idx <= 4'd0;
          end else begin
            idx        <= idx + 4'd1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        FINISH: begin
          done <= 1'b1;
          pass <= (mismatch_count == 5'd0);
        end
        default: begin
          idx <= 4'd0;
        end
      endcase
    end
  end

endmodule
